bin_to_bcd_seq: RTL

Parametrised, sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm. Takes an unsigned `BIN_W`-bit value and produces `DIGITS` packed BCD digits after a fixed number of clock cycles. It sits between the scoreboard counters and the seven-segment digit drivers. It supports arbitrary score widths and digit counts, with a start/ready/done handshake and overflow saturation.

---
 rtl/bin_to_bcd_pkg.sv | 29 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and elaboration-time helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest value representable in `digits` decimal digits (valid up to 38 digits).
  function automatic logic [127:0] pow10_minus1(input int unsigned digits);
    logic [127:0] p;
    p = 128'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 128'd10;
    end
    return p - 128'd1;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/ready/done
// handshake and saturation to all nines on overflow.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  overflow_o
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = clog2(BIN_W + 1);
  localparam int unsigned TW    = ((BIN_W > BCD_W) ? BIN_W : BCD_W) + 1;

  localparam logic [TW-1:0]    THRESH  = TW'(pow10_minus1(DIGITS));
  localparam logic [TW-1:0]    BIN_MAX = {{(TW - BIN_W){1'b0}}, {BIN_W{1'b1}}};
  // Overflow is impossible when every input fits in DIGITS digits.
  localparam bit               OVF_EN  = (THRESH < BIN_MAX);
  localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               ovf_q;

  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (sr_q[BIN_W + 4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  assign sr_adj   = {bcd_adj, sr_q[BIN_W-1:0]};
  assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && start_i) begin
        sr_q       <= {{BCD_W{1'b0}}, bin_i};
        cnt_q      <= CNT_W'(BIN_W);
        ovf_pend_q <= OVF_EN && ({{(TW - BIN_W){1'b0}}, bin_i} > THRESH);
      end else if (state_q == CONV) begin
        sr_q  <= sr_shift;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_q <= ovf_pend_q ? NINES : sr_shift[SR_W-1:BIN_W];
          ovf_q <= ovf_pend_q;
        end
      end
    end
  end

  assign bcd_o      = bcd_q;
  assign overflow_o = ovf_q;

endmodule
